// File: rtl/sched_info_dispatcher.sv
// Round-robin dispatcher of pending scheduling-info entries onto a valid/ready descriptor stream.
// Latency: pending bit at cycle N -> mem_en at N -> out_valid at N+2; one descriptor per 3 cycles at best.
// Backpressure: out_ready low holds the descriptor in OUT; new notifications keep accumulating in pending.
module sched_info_dispatcher #(
    parameter  int MAX_ACCS = 16,
    localparam int ACC_BITS = $clog2(MAX_ACCS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sched_set_valid,
    input  logic [ACC_BITS-1:0] sched_set_acc,
    output logic [ACC_BITS-1:0] mem_addr,
    output logic                mem_en,
    input  logic [49:0]         mem_dout,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_BITS-1:0] out_acc,
    output logic [49:0]         out_data,
    output logic [MAX_ACCS-1:0] pending
);

    typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ACC_BITS-1:0] rr_ptr;
    logic [ACC_BITS-1:0] grant;
    logic                grant_vld;
    logic [MAX_ACCS-1:0] set_mask;
    logic [MAX_ACCS-1:0] clr_mask;

    // First pending entry at or above rr_ptr, wrapping past MAX_ACCS-1 back to 0.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < MAX_ACCS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= MAX_ACCS) idx = idx - MAX_ACCS;
            if (!grant_vld && pending[idx]) begin
                grant     = ACC_BITS'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    // Decode the notification; indices beyond the table are dropped.
    always_comb begin
        set_mask = '0;
        if (sched_set_valid && (int'(sched_set_acc) < MAX_ACCS)) set_mask[sched_set_acc] = 1'b1;
    end

    // Next-state and read-port control; the read is issued in the grant cycle itself.
    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_addr  = '0;
        clr_mask  = '0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    mem_en          = 1'b1;
                    mem_addr        = grant;
                    clr_mask[grant] = 1'b1;
                    state_nxt       = WAIT;
                end
            end
            WAIT:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == OUT);

    // State, pending set (set wins over a same-cycle grant clear), pointer and descriptor registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            pending  <= '0;
            rr_ptr   <= '0;
            out_acc  <= '0;
            out_data <= '0;
        end else begin
            state   <= state_nxt;
            pending <= (pending & ~clr_mask) | set_mask;
            if (state == IDLE && grant_vld) begin
                out_acc <= grant;
                rr_ptr  <= (grant == ACC_BITS'(MAX_ACCS - 1)) ? '0 : grant + ACC_BITS'(1);
            end
            if (state == WAIT) out_data <= mem_dout;
        end
    end

endmodule

// File: tb/tb_sched_info_dispatcher.sv
// Scoreboard bench for sched_info_dispatcher: behavioural memory, expected descriptors queued at stimulus time.
// Latency: descriptors compared at the handshake cycle on the falling edge.
// Backpressure: out_ready is driven by the bench to hold or release descriptors.
module tb_sched_info_dispatcher;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sched_set_valid;
    logic [3:0]  sched_set_acc;
    logic [3:0]  mem_addr;
    logic        mem_en;
    logic [49:0] mem_dout;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_acc;
    logic [49:0] out_data;
    logic [15:0] pending;

    // second instance with a non-power-of-two table for out-of-range notifications
    logic        set_valid2;
    logic [3:0]  set_acc2;
    logic [3:0]  mem_addr2;
    logic        mem_en2;
    logic        out_valid2;
    logic [3:0]  out_acc2;
    logic [49:0] out_data2;
    logic [11:0] pending2;

    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [49:0] wr_data;
    logic [49:0] mem [16];

    typedef struct packed {
        logic [3:0]  acc;
        logic [49:0] data;
    } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sched_info_dispatcher #(.MAX_ACCS(16)) dut (
        .clk(clk), .rstn(rstn),
        .sched_set_valid(sched_set_valid), .sched_set_acc(sched_set_acc),
        .mem_addr(mem_addr), .mem_en(mem_en), .mem_dout(mem_dout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_data(out_data), .pending(pending)
    );

    sched_info_dispatcher #(.MAX_ACCS(12)) u12 (
        .clk(clk), .rstn(rstn),
        .sched_set_valid(set_valid2), .sched_set_acc(set_acc2),
        .mem_addr(mem_addr2), .mem_en(mem_en2), .mem_dout(50'h0),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_acc(out_acc2), .out_data(out_data2), .pending(pending2)
    );

    // Registered-read memory: a read in the write cycle returns the old contents.
    always @(posedge clk) begin
        if (mem_en) mem_dout <= mem[mem_addr];
        if (wr_en)  mem[wr_addr] <= wr_data;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Compare every accepted descriptor against the head of the expected queue.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("desc_expected_cnt", 64'(exp_q.size()), 64'd1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("desc_acc", 64'(out_acc), 64'(e.acc));
                chk("desc_data", 64'(out_data), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic notify(input logic [3:0] acc, input logic [49:0] d);
        wr_en = 1'b1; wr_addr = acc; wr_data = d;
        sched_set_valid = 1'b1; sched_set_acc = acc;
        tick();
        wr_en = 1'b0; sched_set_valid = 1'b0;
    endtask

    task automatic notify2(input logic [3:0] acc);
        set_valid2 = 1'b1; set_acc2 = acc;
        tick();
        set_valid2 = 1'b0;
    endtask

    task automatic expect_desc(input logic [3:0] acc, input logic [49:0] d);
        exp_t e;
        e.acc  = acc;
        e.data = d;
        exp_q.push_back(e);
    endtask

    function automatic logic [49:0] mkdat(input logic [3:0] acc);
        logic [31:0] r;
        r = $urandom;
        return {2'b10, r, 12'h0A5, acc};
    endfunction

    // Release exactly one held descriptor.
    task automatic accept_one();
        for (int i = 0; i < 50 && !out_valid; i++) tick();
        chk("accept_vld", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && !out_valid && !mem_en && pending == 16'h0) break;
            tick();
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("drain_pending", 64'(pending), 64'd0);
    endtask

    logic [49:0] d;
    logic [49:0] d4;
    logic [49:0] d9;

    initial begin
        rstn = 1'b0; sched_set_valid = 1'b0; sched_set_acc = '0; out_ready = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; set_valid2 = 1'b0; set_acc2 = '0;
        #12;
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_acc", 64'(out_acc), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_pending12", 64'(pending2), 64'd0);
        @(negedge clk); rstn = 1'b1;
        tick();

        // single dispatch with exact latency
        expect_desc(4'd5, 50'h3_DEAD_BEEF_0005);
        notify(4'd5, 50'h3_DEAD_BEEF_0005);
        chk("t1_mem_en", 64'(mem_en), 64'd1);
        chk("t1_mem_addr", 64'(mem_addr), 64'd5);
        chk("t1_pending", 64'(pending), 64'h20);
        tick();
        chk("t1_wait_mem_en", 64'(mem_en), 64'd0);
        chk("t1_wait_valid", 64'(out_valid), 64'd0);
        tick();
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_acc", 64'(out_acc), 64'd5);
        chk("t1_out_data", 64'(out_data), 64'h3_DEAD_BEEF_0005);
        chk("t1_pending_clr", 64'(pending), 64'd0);
        drain();

        // round-robin order and pointer wrap
        out_ready = 1'b0;
        d = mkdat(4'd1);  expect_desc(4'd1, d);  notify(4'd1, d);
        d = mkdat(4'd15); notify(4'd15, d); expect_desc(4'd2, 50'h0);
        exp_q[exp_q.size()-1] = '0;
        exp_q.delete(exp_q.size()-1);
        begin
            logic [49:0] d2, d7, d15;
            d15 = d;
            d7 = mkdat(4'd7); notify(4'd7, d7);
            d2 = mkdat(4'd2); notify(4'd2, d2);
            chk("t2_pending", 64'(pending), 64'h8084);
            expect_desc(4'd2, d2);
            expect_desc(4'd7, d7);
            expect_desc(4'd15, d15);
            accept_one();
            accept_one();
            accept_one();
            d2 = mkdat(4'd2); notify(4'd2, d2);
            d  = mkdat(4'd0); notify(4'd0, d);
            chk("t2_pending_wrap", 64'(pending), 64'h0005);
            expect_desc(4'd0, d);
            expect_desc(4'd2, d2);
            accept_one();
            accept_one();
            accept_one();
        end
        out_ready = 1'b1;
        drain();

        // backpressure: descriptor held stable, pending accumulates
        out_ready = 1'b0;
        d9 = mkdat(4'd9); expect_desc(4'd9, d9); notify(4'd9, d9);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        d = mkdat(4'd3); expect_desc(4'd3, d); notify(4'd3, d);
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_acc", 64'(out_acc), 64'd9);
            chk("t3_hold_data", 64'(out_data), 64'(d9));
            tick();
        end
        chk("t3_pending3", 64'(pending), 64'h0008);
        out_ready = 1'b1;
        drain();

        // set and grant of the same entry in one cycle: set wins, two dispatches
        d4 = mkdat(4'd4);
        expect_desc(4'd4, d4);
        expect_desc(4'd4, d4);
        notify(4'd4, d4);
        chk("t4_mem_en", 64'(mem_en), 64'd1);
        chk("t4_mem_addr", 64'(mem_addr), 64'd4);
        notify(4'd4, d4);
        chk("t4_pending_kept", 64'(pending), 64'h0010);
        drain();

        // asynchronous reset while in WAIT discards everything
        notify(4'd6, mkdat(4'd6));
        notify(4'd8, mkdat(4'd8));
        #2 rstn = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_mem_en", 64'(mem_en), 64'd0);
        chk("t5_rst_pending", 64'(pending), 64'd0);
        @(negedge clk); rstn = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("t5_quiet_valid", 64'(out_valid), 64'd0);
        chk("t5_quiet_mem_en", 64'(mem_en), 64'd0);
        d = mkdat(4'd1); expect_desc(4'd1, d); notify(4'd1, d);
        chk("t5_new_addr", 64'(mem_addr), 64'd1);
        drain();

        // out-of-range notifications on the 12-entry instance
        notify2(4'd15);
        chk("t6_pending15", 64'(pending2), 64'd0);
        chk("t6_mem_en15", 64'(mem_en2), 64'd0);
        notify2(4'd12);
        chk("t6_pending12", 64'(pending2), 64'd0);
        chk("t6_mem_en12", 64'(mem_en2), 64'd0);
        notify2(4'd11);
        chk("t6_pending11", 64'(pending2), 64'h800);
        chk("t6_mem_en11", 64'(mem_en2), 64'd1);
        chk("t6_mem_addr11", 64'(mem_addr2), 64'd11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
